fir_da_sequencer: RTL and testbench
===================================

# fir_da_sequencer

Parametrised control sequencer for the distributed-arithmetic (DA) FIR datapath. It accepts input samples over a valid/ready handshake, writes each sample into the coefficient-tap FIFO of one of `NUM_CH` time-multiplexed channels, and runs the bit-serial DA engine for `DATA_W` cycles. It then presents a result-valid strobe tagged with the channel number, under output backpressure. It sits between the sample source and the FIFO/DA datapath, and provides synchronous clear and flush control.

## Interface
- `DATA_W`, 16: sample width; equals the number of DA bit-serial cycles per sample (≥2).
- `NUM_CH`, 4: number of interleaved channels (≥1).
- `CH_W`, `max(1,$clog2(NUM_CH))`: channel index width (derived).
- `BIT_W`, `max(1,$clog2(DATA_W))`: bit index width (derived).
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous soft clear; aborts any sample in progress.
- `in_valid` in 1: sample offered.
- `in_data` in DATA_W: sample value.
- `in_ready` out 1: sequencer accepts the sample this cycle.
- `out_ready` in 1: downstream accepts the result.
- `fifo_en` out 1: shift `fifo_din` into the FIFO selected by `fifo_sel`.
- `fifo_din` out DATA_W: registered accepted sample.
- `fifo_sel` out CH_W: channel of the current sample.
- `fifo_clr_n` out 1: active-low clear to all channel FIFOs.
- `da_clr` out 1: clear the DA accumulator.
- `da_en` out 1: DA engine processes bit `da_bit_idx` this cycle.
- `da_bit_idx` out BIT_W: current bit, 0 = LSB.
- `da_last` out 1: final (sign, MSB) bit; the DA engine subtracts instead of adding.
- `out_valid` out 1: DA result for `out_ch` is valid.
- `out_ch` out CH_W: channel of the result.
- `out_frame_end` out 1: `out_valid` AND `out_ch == NUM_CH-1`.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - CLEAR: 1 cycle, entered on reset or flush.
  - IDLE.
  - LOAD: 1 cycle.
  - ACCUM: DATA_W cycles.
  - DONE: held until `out_ready`.
- Transitions:
  - `resetn=0` → CLEAR. This has the highest priority.
  - Otherwise, `flush=1` → CLEAR from any state.
  - CLEAR → IDLE.
  - IDLE → LOAD when `in_valid`.
  - LOAD → ACCUM.
  - ACCUM → DONE when `bit_cnt == DATA_W-1`.
  - DONE → IDLE when `out_ready` and not `in_valid`.
  - DONE → LOAD when `out_ready` and `in_valid`.
  - DONE stays in DONE when `out_ready` is low.
- `in_ready` = (IDLE) OR (DONE AND `out_ready`), and is forced to 0 when `flush` is 1. This is the only combinational input-to-output path.
- On accept (`in_valid && in_ready`):
  - `fifo_din` ← `in_data`.
  - `fifo_sel` ← `ch_cnt`.
  - `ch_cnt` ← `ch_cnt+1`, wrapping from NUM_CH-1 to 0. With NUM_CH=1, `ch_cnt` stays at 0.
- Output decode by state:
  - LOAD: `fifo_en=1`, `da_clr=1`.
  - ACCUM: `da_en=1`, `da_bit_idx=bit_cnt`, `da_last=(bit_cnt==DATA_W-1)`.
  - DONE: `out_valid=1`, `out_ch=fifo_sel`.
  - CLEAR: `fifo_clr_n=0`, `da_clr=1`.
- `bit_cnt` is cleared on entering ACCUM and increments once per ACCUM cycle.
- CLEAR resets `ch_cnt` to 0. An aborted sample produces no `out_valid`.
- Reset/CLEAR output values:
  - `in_ready=0`, `fifo_en=0`, `fifo_din=0`, `fifo_sel=0`.
  - `fifo_clr_n=0`, `da_clr=1`, `da_en=0`, `da_bit_idx=0`, `da_last=0`.
  - `out_valid=0`, `out_ch=0`, `out_frame_end=0`, `busy=1`.
- In IDLE all outputs are inactive: `fifo_clr_n=1`, `da_clr=0`, `busy=0`, `in_ready=1`.

## Timing
- Reset sampled at edge R → CLEAR during cycle R+1 (for the whole reset assertion) → IDLE at the first cycle after `resetn` returns high.
- Sample accepted at edge T:
  - LOAD in cycle T+1.
  - ACCUM in cycles T+2 … T+1+DATA_W, with `da_last` in cycle T+1+DATA_W.
  - DONE from cycle T+2+DATA_W.
- Latency: accept to `out_valid` = DATA_W+2 cycles.
- Sustained throughput with `out_ready=1` and back-to-back input: one sample per DATA_W+2 cycles. DONE→LOAD loses no extra cycle.
- `out_valid` stays high and `out_ch` stays stable until a cycle with `out_ready=1`. The result completes at that edge.
- `flush` during DONE with `out_ready=1`: the flush wins. No new sample is accepted, because `in_ready` is forced to 0. The result in DONE counts as consumed.

## Test plan
- Reset, DATA_W=16, NUM_CH=4: hold `resetn=0` for 3 cycles → `fifo_clr_n=0`, `da_clr=1`, `in_ready=0` throughout. Release → next cycle IDLE, `in_ready=1`, `busy=0`.
- Single sample 0x8001 at edge T:
  - `fifo_en=1` with `fifo_din=0x8001`, `fifo_sel=0` at T+1.
  - `da_en` high for 16 cycles, `da_bit_idx` 0..15.
  - `da_last` only at T+17.
  - `out_valid`, `out_ch=0` at T+18.
- Back-to-back stream of 9 samples, `out_ready=1` → `out_ch` sequence 0,1,2,3,0,1,2,3,0. Spacing is 18 cycles. `out_frame_end` on the 4th and 8th results.
- Backpressure: `out_ready=0` for 5 cycles in DONE → `out_valid` held 5 cycles, `in_ready=0`, `out_ch` stable. When `out_ready` rises with `in_valid=1`, the sample is accepted the same cycle and LOAD follows.
- Flush at ACCUM bit 7 → CLEAR next cycle, no `out_valid` for that sample, `ch_cnt=0`. The next accepted sample gets `fifo_sel=0`.
- NUM_CH=1, DATA_W=2 → latency 4 cycles, `out_ch` always 0, `out_frame_end` on every result.

Source files
------------

// File: rtl/fir_da_sequencer.sv
// fir_da_sequencer: valid/ready sample sequencer driving a channel-interleaved bit-serial DA FIR datapath
module fir_da_sequencer #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              fifo_en,
   output logic [DATA_W-1:0] fifo_din,
   output logic [CH_W-1:0]   fifo_sel,
   output logic              fifo_clr_n,
   output logic              da_clr,
   output logic              da_en,
   output logic [BIT_W-1:0]  da_bit_idx,
   output logic              da_last,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_frame_end,
   output logic              busy
);
   typedef enum logic [2:0] {CLEAR, IDLE, LOAD, ACCUM, DONE} state_t;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   state_t state, state_nxt;
   logic [BIT_W-1:0] bit_cnt;
   logic [CH_W-1:0] ch_cnt;
   logic accept;
   assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
   assign accept = in_valid && in_ready;
   assign out_frame_end = out_valid && out_ch == LAST_CH;
   assign busy = state != IDLE;
   // state register: reset and flush both land in CLEAR
   always_ff @(posedge clk)
      state <= (!resetn || flush) ? CLEAR : state_nxt;
   // sample capture, channel rotation and bit counter
   always_ff @(posedge clk)
      if (!resetn || flush) begin
         bit_cnt  <= '0;
         ch_cnt   <= '0;
         fifo_din <= '0;
         fifo_sel <= '0;
      end else begin
         bit_cnt <= (state == ACCUM) ? bit_cnt + 1'b1 : '0;
         if (accept) begin
            fifo_din <= in_data;
            fifo_sel <= ch_cnt;
            ch_cnt   <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
         end
      end
   // next-state and per-state output decode
   always_comb begin
      state_nxt  = state;
      fifo_en    = 1'b0;
      fifo_clr_n = 1'b1;
      da_clr     = 1'b0;
      da_en      = 1'b0;
      da_bit_idx = '0;
      da_last    = 1'b0;
      out_valid  = 1'b0;
      out_ch     = '0;
      case (state)
         CLEAR: begin
            state_nxt  = IDLE;
            fifo_clr_n = 1'b0;
            da_clr     = 1'b1;
         end
         IDLE: state_nxt = in_valid ? LOAD : IDLE;
         LOAD: begin
            state_nxt = ACCUM;
            fifo_en   = 1'b1;
            da_clr    = 1'b1;
         end
         ACCUM: begin
            state_nxt  = (bit_cnt == LAST_BIT) ? DONE : ACCUM;
            da_en      = 1'b1;
            da_bit_idx = bit_cnt;
            da_last    = bit_cnt == LAST_BIT;
         end
         DONE: begin
            state_nxt = out_ready ? (in_valid ? LOAD : IDLE) : DONE;
            out_valid = 1'b1;
            out_ch    = fifo_sel;
         end
         default: state_nxt = CLEAR;
      endcase
   end
endmodule

// File: tb/tb_fir_da_sequencer.sv
// tb_fir_da_sequencer: checks a 16-bit/4-channel and a 2-bit/1-channel sequencer against a timing model
module tb_fir_da_sequencer;
   logic clk = 1'b0;
   logic resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic in_ready0, fifo_en0, fifo_clr_n0, da_clr0, da_en0, da_last0, out_valid0, out_frame_end0, busy0;
   logic [15:0] fifo_din0;
   logic [1:0] fifo_sel0, out_ch0;
   logic [3:0] da_bit_idx0;
   logic in_ready1, fifo_en1, fifo_clr_n1, da_clr1, da_en1, da_last1, out_valid1, out_frame_end1, busy1;
   logic [1:0] fifo_din1;
   logic [0:0] fifo_sel1, out_ch1, da_bit_idx1;
   logic [32:0] obs [2];
   int vectors = 0, miss = 0, cyc = 0;
   bit clr [2] = '{1'b1, 1'b1};
   bit active [2] = '{1'b0, 1'b0};
   int age [2], cch [2], chc [2];
   logic [15:0] cdata [2];

   always #5 clk = ~clk;

   fir_da_sequencer #(.DATA_W(16), .NUM_CH(4)) u0 (
      .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .out_ready(out_ready), .fifo_en(fifo_en0), .fifo_din(fifo_din0),
      .fifo_sel(fifo_sel0), .fifo_clr_n(fifo_clr_n0), .da_clr(da_clr0), .da_en(da_en0),
      .da_bit_idx(da_bit_idx0), .da_last(da_last0), .out_valid(out_valid0), .out_ch(out_ch0),
      .out_frame_end(out_frame_end0), .busy(busy0));

   fir_da_sequencer #(.DATA_W(2), .NUM_CH(1)) u1 (
      .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data[1:0]),
      .in_ready(in_ready1), .out_ready(out_ready), .fifo_en(fifo_en1), .fifo_din(fifo_din1),
      .fifo_sel(fifo_sel1), .fifo_clr_n(fifo_clr_n1), .da_clr(da_clr1), .da_en(da_en1),
      .da_bit_idx(da_bit_idx1), .da_last(da_last1), .out_valid(out_valid1), .out_ch(out_ch1),
      .out_frame_end(out_frame_end1), .busy(busy1));

   assign obs[0] = {in_ready0, fifo_en0, fifo_din0, fifo_sel0, fifo_clr_n0, da_clr0, da_en0,
                    da_bit_idx0, da_last0, out_valid0, out_ch0, out_frame_end0, busy0};
   assign obs[1] = {in_ready1, fifo_en1, 14'd0, fifo_din1, 1'b0, fifo_sel1, fifo_clr_n1, da_clr1, da_en1,
                    3'd0, da_bit_idx1, da_last1, out_valid1, 1'b0, out_ch1, out_frame_end1, busy1};

   // Expected outputs from elapsed time since the sample was accepted:
   // 1 cycle of load, DATA_W bit cycles, then the result waits for out_ready.
   function automatic logic [32:0] exp_vec(int k);
      int dw = k ? 2 : 16;
      int nc = k ? 1 : 4;
      bit dn = active[k] && age[k] >= dw + 2;
      bit ld = active[k] && age[k] == 1;
      bit ac = active[k] && age[k] >= 2 && age[k] <= dw + 1;
      int b = ac ? age[k] - 2 : 0;
      bit rdy = !flush && ((!clr[k] && !active[k]) || (dn && out_ready));
      return {rdy, ld, cdata[k], 2'(cch[k]), !clr[k], clr[k] || ld, ac, 4'(b), ac && b == dw - 1,
              dn, dn ? 2'(cch[k]) : 2'd0, dn && cch[k] == nc - 1, clr[k] || active[k]};
   endfunction

   // advance one clock and the reference model with it; returns at the following falling edge
   task automatic step();
      bit acc [2];
      bit dn [2];
      logic [32:0] e;
      for (int k = 0; k < 2; k++) begin
         e = exp_vec(k);
         acc[k] = in_valid && e[32];
         dn[k] = e[23 - (0)] == 1'b0 ? (active[k] && age[k] >= (k ? 4 : 18)) : (active[k] && age[k] >= (k ? 4 : 18));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!resetn || flush) begin
            clr[k] = 1'b1; active[k] = 1'b0; chc[k] = 0; cch[k] = 0; cdata[k] = '0;
         end else begin
            clr[k] = 1'b0;
            if (dn[k] && out_ready) active[k] = 1'b0;
            if (acc[k]) begin
               active[k] = 1'b1;
               age[k] = 1;
               cdata[k] = k ? {14'd0, in_data[1:0]} : in_data;
               cch[k] = chc[k];
               chc[k] = (chc[k] + 1) % (k ? 1 : 4);
            end else if (active[k]) age[k]++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL reset dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         vectors++;
         if ({fifo_clr_n0, da_clr0, in_ready0} !== 3'b010) begin miss++; $display("FAIL reset_hold got %b exp 010", {fifo_clr_n0, da_clr0, in_ready0}); end
      end
      resetn = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL reset_release dut%0d got %h exp %h", k, obs[k], exp_vec(k)); end
      end
      vectors++;
      if ({in_ready0, busy0} !== 2'b10) begin miss++; $display("FAIL reset_idle got %b exp 10", {in_ready0, busy0}); end
   endtask

   task automatic test_single();
      int lat0 = -1, lat1 = -1, last_at = -1, bits = 0;
      in_valid = 1'b1; in_data = 16'h8001; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++;
      if ({fifo_en0, fifo_din0, fifo_sel0} !== {1'b1, 16'h8001, 2'd0}) begin miss++; $display("FAIL single_load got %b %h %0d exp 1 8001 0", fifo_en0, fifo_din0, fifo_sel0); end
      for (int n = 1; n <= 22; n++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL single dut%0d n %0d got %h exp %h", k, n, obs[k], exp_vec(k)); end
         end
         if (da_en0) begin
            vectors++;
            if (da_bit_idx0 !== 4'(bits)) begin miss++; $display("FAIL single_bit got %0d exp %0d", da_bit_idx0, bits); end
            bits++;
         end
         if (da_last0 && last_at < 0) last_at = n;
         if (out_valid0 && lat0 < 0) lat0 = n;
         if (out_valid1 && lat1 < 0) lat1 = n;
         step();
      end
      vectors++;
      if ({lat0, lat1, last_at, bits} !== {32'd18, 32'd4, 32'd17, 32'd16}) begin
         miss++; $display("FAIL single_timing got lat %0d/%0d last %0d bits %0d exp 18/4 17 16", lat0, lat1, last_at, bits);
      end
   endtask

   task automatic test_back_to_back();
      int acc0 = 0, res = 0, prev = -1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int n = 0; n < 220 && res < 9; n++) begin
         in_data = 16'($urandom);
         if (in_valid && in_ready0) acc0++;
         step();
         if (acc0 == 9) in_valid = 1'b0;
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL b2b dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         if (out_valid1) begin
            vectors++;
            if ({out_ch1, out_frame_end1} !== 2'b01) begin miss++; $display("FAIL single_ch got %b exp 01", {out_ch1, out_frame_end1}); end
         end
         if (out_valid0) begin
            vectors++;
            if ({out_ch0, out_frame_end0} !== {2'(res % 4), res % 4 == 3}) begin
               miss++; $display("FAIL b2b_ch result %0d got %0d/%b exp %0d/%b", res, out_ch0, out_frame_end0, res % 4, res % 4 == 3);
            end
            if (prev >= 0) begin
               vectors++;
               if (n - prev !== 18) begin miss++; $display("FAIL b2b_spacing got %0d exp 18", n - prev); end
            end
            prev = n; res++;
         end
      end
      vectors++;
      if (res !== 9) begin miss++; $display("FAIL b2b_count got %0d exp 9", res); end
      in_valid = 1'b0;
      for (int n = 0; n < 4; n++) step();
   endtask

   task automatic test_backpressure();
      logic [1:0] held;
      bit found = 1'b0;
      in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL bp dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         if (out_valid0) found = 1'b1; else step();
      end
      vectors++;
      if (!found) begin miss++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
      held = out_ch0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({out_valid0, in_ready0, out_ch0} !== {2'b10, held}) begin
            miss++; $display("FAIL bp_hold cycle %0d got %b%b ch %0d exp 10 ch %0d", i, out_valid0, in_ready0, out_ch0, held);
         end
         step();
      end
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'hbeef;
      #1;
      vectors++;
      if (in_ready0 !== 1'b1) begin miss++; $display("FAIL bp_release_ready got %b exp 1", in_ready0); end
      step();
      in_valid = 1'b0;
      vectors++;
      if ({fifo_en0, fifo_din0} !== {1'b1, 16'hbeef}) begin miss++; $display("FAIL bp_load got %b %h exp 1 beef", fifo_en0, fifo_din0); end
      for (int n = 0; n < 22; n++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL bp_drain dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         step();
      end
   endtask

   task automatic test_flush();
      bit seen = 1'b0, found = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0f0f;
      step();
      for (int n = 0; n < 60 && !found; n++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL flush_run dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         if (seen && da_en0 && da_bit_idx0 == 4'd7) found = 1'b1;
         else begin
            if (out_valid0) seen = 1'b1;
            step();
            if (seen) in_valid = 1'b0;
         end
      end
      vectors++;
      if (!found) begin miss++; $display("FAIL flush_timeout got no bit 7 exp bit 7"); end
      in_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      vectors++;
      if ({fifo_clr_n0, da_clr0, busy0, in_ready0} !== 4'b0110) begin miss++; $display("FAIL flush_clear got %b exp 0110", {fifo_clr_n0, da_clr0, busy0, in_ready0}); end
      for (int n = 0; n < 25; n++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL flush_quiet dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
         vectors++;
         if (out_valid0 !== 1'b0) begin miss++; $display("FAIL flush_no_result got %b exp 0", out_valid0); end
      end
      in_valid = 1'b1; in_data = 16'h5a5a;
      step();
      in_valid = 1'b0;
      vectors++;
      if ({fifo_en0, fifo_sel0} !== 3'b100) begin miss++; $display("FAIL flush_sel got %b %0d exp 1 0", fifo_en0, fifo_sel0); end
      for (int n = 0; n < 20; n++) step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         in_valid = ($urandom % 3) != 0;
         out_ready = ($urandom % 4) != 0;
         flush = ($urandom % 60) == 0;
         resetn = ($urandom % 300) != 0;
         in_data = 16'($urandom);
         step();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin miss++; $display("FAIL random dut%0d cyc %0d got %h exp %h", k, cyc, obs[k], exp_vec(k)); end
         end
      end
      flush = 1'b0; resetn = 1'b1; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end
endmodule
